// File: rtl/prbs_checker_if.sv
// ============================================================================
// Module      : prbs_checker_if
// Description : Sample stream and status bundle between an upstream source
//               and prbs_checker. The master drives the samples and the
//               counter clear. The slave (the checker) returns lock state
//               and error statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prbs_checker_if #(
  parameter int N  = 4,
  parameter int CW = 16
);

  logic          in_valid;
  logic [N:1]    in_data;
  logic          clear;
  logic          locked;
  logic          err_pulse;
  logic [CW-1:0] err_count;

  // Source side: drives the samples and the clear, observes status.
  modport master (
    output in_valid,
    output in_data,
    output clear,
    input  locked,
    input  err_pulse,
    input  err_count
  );

  // Checker side.
  modport slave (
    input  in_valid,
    input  in_data,
    input  clear,
    output locked,
    output err_pulse,
    output err_count
  );

endinterface

`default_nettype wire

// File: rtl/prbs_checker.sv
// ============================================================================
// Module      : prbs_checker
// Description : Self-synchronising checker for the Fibonacci LFSR pattern
//               generator. In SEARCH the predictor is reseeded from every
//               valid sample. After LOCK_THRESH consecutive correct
//               predictions the checker locks. It then free-runs the
//               predictor and counts mismatching samples. LOSS_THRESH
//               consecutive mismatches return it to SEARCH.
//               Optional feature macro: PRBS_CHK_BITERR_EN. When it is
//               defined, err_count accumulates bit errors instead of word
//               errors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prbs_checker #(
  parameter int         N           = 4,
  parameter logic [N:1] TAPS        = 4'b0011,
  parameter int         LOCK_THRESH = 4,
  parameter int         LOSS_THRESH = 3,
  parameter int         CW          = 16
) (
  input  wire logic           clk,
  input  wire logic           reset,
  prbs_checker_if.slave       bus
);

  // Threshold counters are 8 bits wide because both thresholds are at most
  // 255. The counters are compared against threshold-1 so that the
  // "count+1 == threshold" test needs no wider adder.
  localparam logic [7:0] c_lock_last = 8'(LOCK_THRESH - 1);
  localparam logic [7:0] c_loss_last = 8'(LOSS_THRESH - 1);

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t        r_state;
  logic [N:1]    r_pred;
  logic [7:0]    r_mcnt;
  logic [7:0]    r_lcnt;
  logic          r_locked;
  logic          r_err_pulse;
  logic [CW-1:0] r_err_count;

  logic          w_match;
  logic          w_err;
  logic [CW-1:0] w_weight;
  logic [CW:0]   w_sum;
  logic [CW-1:0] w_count_sat;

  // Generator step: shift right and feed the tap parity into bit N.
  function automatic logic [N:1] lfsr_next(input logic [N:1] s);
    return {^(s & TAPS), s[N:2]};
  endfunction

  // An all-zero word is the LFSR lock-up state and never counts as a match,
  // even if the predictor happens to hold zero as well (as it does after reset).
  assign w_match = (bus.in_data == r_pred) && (bus.in_data != '0);

  // Errors are only recognised on valid samples while locked.
  assign w_err   = bus.in_valid && (r_state == ST_LOCKED) && !w_match;

`ifdef PRBS_CHK_BITERR_EN
  logic [N:1] w_diff;

  // Error weight is the number of differing bit positions.
  always_comb begin
    w_diff   = bus.in_data ^ r_pred;
    w_weight = '0;
    for (int i = 1; i <= N; i++) begin
      w_weight = w_weight + CW'(w_diff[i]);
    end
  end
`else
  assign w_weight = CW'(1);
`endif

  // The extra top bit of the sum detects overflow, so the counter saturates
  // instead of wrapping.
  assign w_sum       = {1'b0, r_err_count} + {1'b0, w_weight};
  assign w_count_sat = w_sum[CW] ? '1 : w_sum[CW-1:0];

  // Lock/loss state machine and flywheel predictor; frozen on invalid cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_SEARCH;
      r_locked <= 1'b0;
      r_pred   <= '0;
      r_mcnt   <= '0;
      r_lcnt   <= '0;
    end else if (bus.in_valid) begin
      case (r_state)
        ST_SEARCH: begin
          // While searching, each sample reseeds the prediction for the next sample.
          r_pred <= lfsr_next(bus.in_data);
          if (w_match) begin
            if (r_mcnt == c_lock_last) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
              r_mcnt   <= '0;
              r_lcnt   <= '0;
            end else begin
              r_mcnt <= r_mcnt + 8'd1;
            end
          end else begin
            r_mcnt <= '0;
          end
        end
        ST_LOCKED: begin
          if (w_match) begin
            r_pred <= lfsr_next(r_pred);
            r_lcnt <= '0;
          end else if (r_lcnt == c_loss_last) begin
            // On loss of lock, reseed from the data so the search can restart at once.
            r_state  <= ST_SEARCH;
            r_locked <= 1'b0;
            r_mcnt   <= '0;
            r_lcnt   <= '0;
            r_pred   <= lfsr_next(bus.in_data);
          end else begin
            r_pred <= lfsr_next(r_pred);
            r_lcnt <= r_lcnt + 8'd1;
          end
        end
        default: begin
          r_state  <= ST_SEARCH;
          r_locked <= 1'b0;
          r_mcnt   <= '0;
          r_lcnt   <= '0;
        end
      endcase
    end
  end

  // Error flag and saturating counter; clear overrides a same-cycle error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_err;
      if (bus.clear) begin
        r_err_count <= '0;
      end else if (w_err) begin
        r_err_count <= w_count_sat;
      end
    end
  end

  assign bus.locked    = r_locked;
  assign bus.err_pulse = r_err_pulse;
  assign bus.err_count = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_prbs_checker.sv
// ============================================================================
// Module      : tb_prbs_checker
// Description : Directed testbench for prbs_checker. A second instance with a
//               4-bit error counter shares the stimulus and makes saturation
//               reachable in a short run. Honours PRBS_CHK_BITERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prbs_checker;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   g;

  prbs_checker_if #(.N(4), .CW(16)) bus ();
  prbs_checker_if #(.N(4), .CW(4))  bus_s ();

  assign bus_s.in_valid = bus.in_valid;
  assign bus_s.in_data  = bus.in_data;
  assign bus_s.clear    = bus.clear;

  prbs_checker #(.CW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  prbs_checker #(.CW(4)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  // One full period of the 4-bit generator (TAPS=0011) starting at 1000.
  logic [4:1] seq [15] = '{4'b1000, 4'b0100, 4'b0010, 4'b1001, 4'b1100,
                           4'b0110, 4'b1011, 4'b0101, 4'b1010, 4'b1101,
                           4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};

`ifdef PRBS_CHK_BITERR_EN
  localparam int c_w0 = 2;  // 0000 vs 0110
  localparam int c_wb = 2;  // 0110 vs 1010
`else
  localparam int c_w0 = 1;
  localparam int c_wb = 1;
`endif

  always #5 clk = ~clk;

  task automatic send(input logic v, input logic [4:1] d, input logic clr);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.clear    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.clear    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b want 0", bus.locked); end
    checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %0b want 0", bus.err_pulse); end
    checks++; if (bus.err_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0h want 0", bus.err_count); end
    checks++; if (bus_s.err_count !== 4'd0) begin errors++; $display("FAIL reset_sat_count: got %0h want 0", bus_s.err_count); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_lock();
    g = 0;
    for (int k = 0; k < 5; k++) begin
      send(1'b1, seq[g % 15], 1'b0);
      g++;
      checks++;
      if (bus.locked !== (k == 4)) begin
        errors++; $display("FAIL lock_seq[%0d]: locked=%0b want %0b", k, bus.locked, (k == 4));
      end
    end
    checks++; if (bus.err_count !== 16'd0) begin errors++; $display("FAIL lock_count: got %0h want 0", bus.err_count); end
    checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL lock_pulse: got %0b want 0", bus.err_pulse); end
  endtask

  task automatic test_single_error();
    send(1'b1, 4'b0000, 1'b0);  // 0110 expected
    g++;
    checks++; if (bus.err_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse: got %0b want 1", bus.err_pulse); end
    checks++; if (bus.err_count !== 16'(c_w0)) begin errors++; $display("FAIL single_count: got %0d want %0d", bus.err_count, c_w0); end
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL single_locked: got %0b want 1", bus.locked); end
    send(1'b1, seq[g % 15], 1'b0);  // 1011 resumes
    g++;
    checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL single_resume_pulse: got %0b want 0", bus.err_pulse); end
    checks++; if (bus.err_count !== 16'(c_w0)) begin errors++; $display("FAIL single_resume_count: got %0d want %0d", bus.err_count, c_w0); end
  endtask

  task automatic test_gap();
    for (int k = 0; k < 3; k++) send(1'b0, 4'b1111, 1'b0);
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL gap_locked: got %0b want 1", bus.locked); end
    checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL gap_pulse: got %0b want 0", bus.err_pulse); end
    send(1'b1, seq[g % 15], 1'b0);
    g++;
    checks++; if (bus.err_count !== 16'(c_w0)) begin errors++; $display("FAIL gap_count: got %0d want %0d", bus.err_count, c_w0); end
    checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL gap_resume_pulse: got %0b want 0", bus.err_pulse); end
  endtask

  task automatic test_biterr();
    send(1'b1, 4'b0110, 1'b0);  // 1010 expected, two bits differ
    g++;
    checks++; if (bus.err_count !== 16'(c_w0 + c_wb)) begin errors++; $display("FAIL biterr_count: got %0d want %0d", bus.err_count, c_w0 + c_wb); end
    checks++; if (bus.err_pulse !== 1'b1) begin errors++; $display("FAIL biterr_pulse: got %0b want 1", bus.err_pulse); end
    send(1'b1, seq[g % 15], 1'b0);
    g++;
  endtask

  task automatic test_loss_relock();
    int base;
    base = c_w0 + c_wb;
    for (int k = 0; k < 3; k++) begin
      send(1'b1, seq[g % 15] ^ 4'b0001, 1'b0);
      g++;
      checks++;
      if (bus.err_count !== 16'(base + k + 1)) begin errors++; $display("FAIL loss_count[%0d]: got %0d want %0d", k, bus.err_count, base + k + 1); end
      checks++;
      if (bus.locked !== (k < 2)) begin errors++; $display("FAIL loss_locked[%0d]: got %0b want %0b", k, bus.locked, (k < 2)); end
    end
    checks++; if (bus.err_pulse !== 1'b1) begin errors++; $display("FAIL loss_pulse: got %0b want 1", bus.err_pulse); end
    for (int k = 0; k < 5; k++) begin
      send(1'b1, seq[g % 15], 1'b0);
      g++;
      checks++;
      if (bus.locked !== (k == 4)) begin errors++; $display("FAIL relock[%0d]: locked=%0b want %0b", k, bus.locked, (k == 4)); end
      checks++;
      if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL relock_pulse[%0d]: got %0b want 0", k, bus.err_pulse); end
    end
    checks++; if (bus.err_count !== 16'(base + 3)) begin errors++; $display("FAIL relock_count_held: got %0d want %0d", bus.err_count, base + 3); end
  endtask

  task automatic test_mid_reset();
    send(1'b1, seq[g % 15] ^ 4'b0001, 1'b0);
    g++;
    checks++; if (bus.err_pulse !== 1'b1) begin errors++; $display("FAIL midrst_pre_pulse: got %0b want 1", bus.err_pulse); end
    reset = 1'b0;
    #1;
    checks++; if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL midrst_pulse: got %0b want 0", bus.err_pulse); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL midrst_locked: got %0b want 0", bus.locked); end
    checks++; if (bus.err_count !== 16'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", bus.err_count); end
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_zero_stream();
    for (int k = 0; k < 20; k++) begin
      send(1'b1, 4'b0000, 1'b0);
      checks++;
      if (bus.locked !== 1'b0 || bus.err_count !== 16'd0) begin
        errors++; $display("FAIL zero_stream[%0d]: locked=%0b count=%0d want 0/0", k, bus.locked, bus.err_count);
      end
    end
  endtask

  task automatic test_saturation();
    g = 0;
    for (int k = 0; k < 5; k++) begin send(1'b1, seq[g % 15], 1'b0); g++; end
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL sat_lock: got %0b want 1", bus.locked); end
    for (int k = 0; k < 16; k++) begin
      send(1'b1, seq[g % 15] ^ 4'b0001, 1'b0); g++;
      send(1'b1, seq[g % 15], 1'b0); g++;
    end
    checks++; if (bus.err_count !== 16'd16) begin errors++; $display("FAIL sat_main_count: got %0d want 16", bus.err_count); end
    checks++; if (bus_s.err_count !== 4'hF) begin errors++; $display("FAIL sat_small_count: got %0h want f", bus_s.err_count); end
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL sat_locked: got %0b want 1", bus.locked); end
    send(1'b1, seq[g % 15] ^ 4'b0001, 1'b0); g++;
    checks++; if (bus_s.err_count !== 4'hF) begin errors++; $display("FAIL sat_hold: got %0h want f", bus_s.err_count); end
    checks++; if (bus.err_count !== 16'd17) begin errors++; $display("FAIL sat_main_17: got %0d want 17", bus.err_count); end
    send(1'b1, seq[g % 15], 1'b0); g++;
    send(1'b1, seq[g % 15] ^ 4'b0001, 1'b1); g++;  // clear with a same-cycle error
    checks++; if (bus.err_count !== 16'd0) begin errors++; $display("FAIL clear_count: got %0d want 0", bus.err_count); end
    checks++; if (bus_s.err_count !== 4'd0) begin errors++; $display("FAIL clear_small_count: got %0d want 0", bus_s.err_count); end
    checks++; if (bus.err_pulse !== 1'b1) begin errors++; $display("FAIL clear_pulse: got %0b want 1", bus.err_pulse); end
    send(1'b1, seq[g % 15], 1'b0); g++;
    checks++; if (bus.err_count !== 16'd0 || bus.err_pulse !== 1'b0) begin errors++; $display("FAIL clear_after: count=%0d pulse=%0b want 0/0", bus.err_count, bus.err_pulse); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk    = 1'b0;
    checks = 0;
    errors = 0;
    g      = 0;
    test_reset();
    test_lock();
    test_single_error();
    test_gap();
    test_biterr();
    test_loss_relock();
    test_mid_reset();
    test_zero_stream();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
